// File: rtl/vector_regbank_grouped_pkg.sv
// rtl/vector_regbank_grouped_pkg.sv - shared types and helpers for the grouped vector register bank
// Group-length and alignment helpers used by the sequencer (optional VREGBANK_BYPASS_EN lives in the read port).
package vector_regbank_grouped_pkg;

  localparam int NUM_VREGS = 32;

  typedef enum logic [1:0] {LMUL1, LMUL2, LMUL4, LMUL8} lmul_e;
  typedef enum logic {IDLE, RUN} vregbank_state_e;

  // Index of the final register in a group of 2^lmul registers.
  function automatic logic [2:0] group_last(lmul_e l);
    case (l)
      LMUL1:   return 3'd0;
      LMUL2:   return 3'd1;
      LMUL4:   return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic is_aligned(logic [4:0] base, lmul_e l);
    return (base[2:0] & group_last(l)) == 3'd0;
  endfunction

endpackage

// File: rtl/vector_regbank_grouped_read_port.sv
// rtl/vector_regbank_grouped_read_port.sv - one combinational register read with optional write-through merge
// VREGBANK_BYPASS_EN adds per-byte forwarding of the in-flight write.
import vector_regbank_grouped_pkg::*;

module vregbank_read_port #(
  parameter int VLEN = 64
) (
  input  logic [NUM_VREGS*VLEN-1:0] regs_flat,
  input  logic [4:0]                addr,
`ifdef VREGBANK_BYPASS_EN
  input  logic [VLEN/8-1:0]         we,
  input  logic [4:0]                vd_addr,
  input  logic [VLEN-1:0]           result,
`endif
  output logic [VLEN-1:0]           data
);

  logic [VLEN-1:0] stored;

  assign stored = regs_flat[addr*VLEN +: VLEN];

`ifdef VREGBANK_BYPASS_EN
  always_comb begin
    data = stored;
    for (int i = 0; i < VLEN/8; i++) begin
      if (we[i] && (vd_addr == addr)) data[8*i +: 8] = result[8*i +: 8];
    end
  end
`else
  assign data = stored;
`endif

endmodule

// File: rtl/vector_regbank_grouped.sv
// rtl/vector_regbank_grouped.sv - 32 x VLEN vector register file with LMUL group read sequencer
// Build with VREGBANK_BYPASS_EN to forward same-cycle writes onto all read outputs.
import vector_regbank_grouped_pkg::*;

module vector_regbank_grouped #(
  parameter int VLEN  = 64,
  parameter int VLENB = VLEN/8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       vs1_base,
  input  logic [4:0]       vs2_base,
  input  logic [4:0]       vs3_base,
  input  logic [1:0]       lmul,
  output logic             req_err,
  output logic             beat_valid,
  input  logic             beat_ready,
  output logic [2:0]       beat_idx,
  output logic             beat_last,
  output logic [VLEN-1:0]  vs1_data,
  output logic [VLEN-1:0]  vs2_data,
  output logic [VLEN-1:0]  vs3_data,
  output logic [VLEN-1:0]  v0_mask,
  input  logic [VLENB-1:0] we,
  input  logic [4:0]       vd_addr,
  input  logic [VLEN-1:0]  result
);

  vregbank_state_e state, state_nx;
  logic [VLEN-1:0]           regs [NUM_VREGS];
  logic [NUM_VREGS*VLEN-1:0] regs_flat;
  logic [4:0]                base1_q, base2_q, base3_q;
  lmul_e                     lmul_q;
  logic [2:0]                cnt;
  logic                      req_ok, is_last;

  assign req_ok  = is_aligned(vs1_base, lmul_e'(lmul)) && is_aligned(vs2_base, lmul_e'(lmul))
                && is_aligned(vs3_base, lmul_e'(lmul));
  assign is_last = (cnt == group_last(lmul_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid && req_ok) state_nx = RUN;
      RUN:     if (beat_ready && is_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    beat_valid = (state == RUN);
    beat_last  = (state == RUN) && is_last;
    beat_idx   = cnt;
  end

  // Bases latch on any request so a rejected one still parks the read address harmlessly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base1_q <= '0;
      base2_q <= '0;
      base3_q <= '0;
      lmul_q  <= LMUL1;
      cnt     <= '0;
      req_err <= 1'b0;
    end else begin
      req_err <= (state == IDLE) && req_valid && !req_ok;
      if (state == IDLE && req_valid) begin
        base1_q <= vs1_base;
        base2_q <= vs2_base;
        base3_q <= vs3_base;
        lmul_q  <= lmul_e'(lmul);
        cnt     <= '0;
      end else if (state == RUN && beat_ready) begin
        cnt <= is_last ? 3'd0 : cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_VREGS; r++) regs[r] <= '0;
    end else begin
      for (int i = 0; i < VLENB; i++) begin
        if (we[i]) regs[vd_addr][8*i +: 8] <= result[8*i +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_VREGS; g++) begin : g_flat
    assign regs_flat[g*VLEN +: VLEN] = regs[g];
  end

  logic [4:0] rd_addr [4];
  logic [VLEN-1:0] rd_data [4];

  assign rd_addr[0] = base1_q + {2'b00, cnt};
  assign rd_addr[1] = base2_q + {2'b00, cnt};
  assign rd_addr[2] = base3_q + {2'b00, cnt};
  assign rd_addr[3] = 5'd0;

  for (genvar p = 0; p < 4; p++) begin : g_rd
    vregbank_read_port #(.VLEN(VLEN)) u_rd (
      .regs_flat (regs_flat),
      .addr      (rd_addr[p]),
`ifdef VREGBANK_BYPASS_EN
      .we        (we),
      .vd_addr   (vd_addr),
      .result    (result),
`endif
      .data      (rd_data[p])
    );
  end

  assign vs1_data = rd_data[0];
  assign vs2_data = rd_data[1];
  assign vs3_data = rd_data[2];
  assign v0_mask  = rd_data[3];

endmodule

// File: tb/tb_vector_regbank_grouped.sv
// tb/tb_vector_regbank_grouped.sv - scoreboard bench for vector_regbank_grouped
// Directed plan scenarios then random traffic; expected beats queued at request time.
module tb_vector_regbank_grouped;

  localparam int VLEN  = 64;
  localparam int VLENB = VLEN/8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [4:0]       vs1_base = '0, vs2_base = '0, vs3_base = '0;
  logic [1:0]       lmul = '0;
  logic             req_err;
  logic             beat_valid;
  logic             beat_ready = 1'b1;
  logic [2:0]       beat_idx;
  logic             beat_last;
  logic [VLEN-1:0]  vs1_data, vs2_data, vs3_data, v0_mask;
  logic [VLENB-1:0] we = '0;
  logic [4:0]       vd_addr = '0;
  logic [VLEN-1:0]  result = '0;

  vector_regbank_grouped #(.VLEN(VLEN)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .vs1_base(vs1_base), .vs2_base(vs2_base), .vs3_base(vs3_base), .lmul(lmul),
    .req_err(req_err), .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_idx(beat_idx), .beat_last(beat_last), .vs1_data(vs1_data),
    .vs2_data(vs2_data), .vs3_data(vs3_data), .v0_mask(v0_mask),
    .we(we), .vd_addr(vd_addr), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         start;
    logic [4:0] b1, b2, b3;
    int         idx;
    int         len;
  } beat_t;

  beat_t           beat_q[$];
  int              err_q[$];
  logic [VLEN-1:0] mem [32];
  int              cyc = 0;
  int              total = 0;
  int              bad = 0;
  int              ready_mode = 0;  // 0 always, 1 alternate, 2 random, 3 manual
  bit              wr_rand = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [VLEN-1:0] act, logic [VLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register value as the reader should see it during the current cycle.
  function automatic logic [VLEN-1:0] model_rd(logic [4:0] a);
    logic [VLEN-1:0] v;
    v = mem[a];
`ifdef VREGBANK_BYPASS_EN
    for (int i = 0; i < VLENB; i++)
      if (we[i] && vd_addr == a) v[8*i +: 8] = result[8*i +: 8];
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      bit exp_bv, exp_err;
      exp_bv = beat_q.size() > 0 && beat_q[0].start <= cyc;
      chk("beat_valid", {63'd0, beat_valid}, {63'd0, exp_bv});
      chk("req_ready", {63'd0, req_ready}, {63'd0, !exp_bv});
      if (err_q.size() > 0 && err_q[0] < cyc) begin
        total++; bad++;
        $display("FAIL req_err_missing: got no pulse expected pulse at cycle %0d", err_q[0]);
        void'(err_q.pop_front());
      end
      exp_err = err_q.size() > 0 && err_q[0] == cyc;
      chk("req_err", {63'd0, req_err}, {63'd0, exp_err});
      if (exp_err) void'(err_q.pop_front());
      if (beat_valid && exp_bv) begin
        beat_t e;
        e = beat_q[0];
        chk("beat_idx", {61'd0, beat_idx}, VLEN'(e.idx));
        chk("beat_last", {63'd0, beat_last}, {63'd0, e.idx == e.len - 1});
        chk("vs1_data", vs1_data, model_rd(5'(e.b1 + e.idx)));
        chk("vs2_data", vs2_data, model_rd(5'(e.b2 + e.idx)));
        chk("vs3_data", vs3_data, model_rd(5'(e.b3 + e.idx)));
        if (beat_ready) void'(beat_q.pop_front());
      end
      chk("v0_mask", v0_mask, model_rd(5'd0));
      for (int i = 0; i < VLENB; i++)
        if (we[i]) mem[vd_addr][8*i +: 8] = result[8*i +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: beat_ready = 1'b1;
      1: beat_ready = ~beat_ready;
      2: beat_ready = ($urandom_range(0, 3) != 0);
      default: ;
    endcase
    if (wr_rand) begin
      we      = ($urandom_range(0, 2) == 0) ? '0 : VLENB'($urandom);
      vd_addr = 5'($urandom);
      result  = {$urandom, $urandom};
    end
  endtask

  task automatic write_reg(logic [4:0] a, logic [VLENB-1:0] m, logic [VLEN-1:0] d);
    we = m; vd_addr = a; result = d;
    tick();
    we = '0;
  endtask

  task automatic issue_req(logic [4:0] b1, logic [4:0] b2, logic [4:0] b3, logic [1:0] lm);
    int n, w;
    w = 0;
    while (!req_ready && w < 200) begin tick(); w++; end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      return;
    end
    n = 1 << lm;
    vs1_base = b1; vs2_base = b2; vs3_base = b3; lmul = lm;
    req_valid = 1'b1;
    if ((b1 % n) != 0 || (b2 % n) != 0 || (b3 % n) != 0) err_q.push_back(cyc + 1);
    else for (int i = 0; i < n; i++) beat_q.push_back('{cyc + 1, b1, b2, b3, i, n});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((beat_q.size() > 0 || err_q.size() > 0) && w < 200) begin tick(); w++; end
    if (beat_q.size() > 0 || err_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", beat_q.size() + err_q.size());
      beat_q.delete(); err_q.delete();
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) mem[r] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_beat_valid", {63'd0, beat_valid}, 64'd0);
    chk("rst_beat_idx", {61'd0, beat_idx}, 64'd0);
    chk("rst_beat_last", {63'd0, beat_last}, 64'd0);
    chk("rst_req_err", {63'd0, req_err}, 64'd0);
    chk("rst_vs1_data", vs1_data, 64'd0);

    write_reg(5'd3, 8'hFF, 64'h1122334455667788);
    issue_req(5'd3, 5'd0, 5'd0, 2'd0);
    drain();
    write_reg(5'd3, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
    issue_req(5'd3, 5'd3, 5'd3, 2'd0);
    drain();

    for (int r = 8; r < 16; r++) write_reg(5'(r), 8'hFF, VLEN'(r));
    ready_mode = 1;
    issue_req(5'd0, 5'd8, 5'd0, 2'd3);
    drain();
    ready_mode = 0;

    issue_req(5'd6, 5'd0, 5'd0, 2'd2);
    repeat (3) tick();
    drain();

    ready_mode = 3;
    beat_ready = 1'b1;
    issue_req(5'd8, 5'd8, 5'd8, 2'd3);
    tick();
    beat_ready = 1'b0;
    we = 8'hFF; vd_addr = 5'd9; result = {8{8'hAA}};
    tick();
    we = '0;
    tick();
    beat_ready = 1'b1;
    drain();
    write_reg(5'd0, 8'h3C, {8{8'h5A}});

    ready_mode = 0;
    issue_req(5'd4, 5'd4, 5'd4, 2'd2);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_beat_valid", {63'd0, beat_valid}, 64'd0);
    chk("midrst_v0_mask", v0_mask, 64'd0);
    beat_q.delete(); err_q.delete();
    for (int r = 0; r < 32; r++) mem[r] = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("postrst_req_ready", {63'd0, req_ready}, 64'd1);
    issue_req(5'd0, 5'd8, 5'd16, 2'd3);
    drain();
    issue_req(5'd24, 5'd24, 5'd24, 2'd3);
    drain();

    ready_mode = 2;
    wr_rand = 1;
    for (int k = 0; k < 150; k++) begin
      logic [1:0] lm;
      logic [4:0] m;
      lm = 2'($urandom);
      m  = 5'((1 << lm) - 1);
      if ($urandom_range(0, 4) == 0)
        issue_req(5'($urandom), 5'($urandom), 5'($urandom), lm);
      else
        issue_req(5'($urandom) & ~m, 5'($urandom) & ~m, 5'($urandom) & ~m, lm);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();
    wr_rand = 0;
    we = '0;
    tick();
    chk("end_beats_pending", 64'(beat_q.size()), 64'd0);
    chk("end_errs_pending", 64'(err_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
